// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, response codes and request-size helpers for mem_ctrl
package mem_ctrl_pkg;

   localparam int ADDR_W      = 32;
   localparam int WORD_W      = 32;
   localparam int MEM_CODE_W  = 2;
   localparam int MEM_COUNT_W = 2;

   localparam logic [MEM_CODE_W-1:0] MEM_CODE_IDLE  = 2'd0;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_BUSY  = 2'd1;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_VALID = 2'd2;
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERROR = 2'd3;

   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
   localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

   function automatic logic [2:0] count_bytes(input logic [MEM_COUNT_W-1:0] count);
      case (count)
         MEM_COUNT_BYTE: count_bytes = 3'd1;
         MEM_COUNT_HALF: count_bytes = 3'd2;
         MEM_COUNT_WORD: count_bytes = 3'd4;
         default:        count_bytes = 3'd0;
      endcase
   endfunction

   // Lane mask of an access starting at lane 0.
   function automatic logic [3:0] count_lanes(input logic [MEM_COUNT_W-1:0] count);
      case (count)
         MEM_COUNT_BYTE: count_lanes = 4'b0001;
         MEM_COUNT_HALF: count_lanes = 4'b0011;
         MEM_COUNT_WORD: count_lanes = 4'b1111;
         default:        count_lanes = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - core request/response and RAM port bundle for mem_ctrl
interface mem_ctrl_if #(
   parameter int RAM_ADDR_W = 10
) ();
   import mem_ctrl_pkg::*;

   logic [ADDR_W-1:0]      i_req_addr;
   logic [WORD_W-1:0]      i_req_wr_data;
   logic                   i_req_wr_en;
   logic [MEM_COUNT_W-1:0] i_req_count;
   logic [WORD_W-1:0]      o_res_rd_data;
   logic [MEM_CODE_W-1:0]  o_res_code;
   logic                   o_ram_en;
   logic                   o_ram_we;
   logic [3:0]             o_ram_be;
   logic [RAM_ADDR_W-1:0]  o_ram_addr;
   logic [WORD_W-1:0]      o_ram_wr_data;
   logic [WORD_W-1:0]      i_ram_rd_data;

   modport slave (
      input  i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count, i_ram_rd_data,
      output o_res_rd_data, o_res_code, o_ram_en, o_ram_we, o_ram_be, o_ram_addr, o_ram_wr_data
   );

   modport master (
      output i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count, i_ram_rd_data,
      input  o_res_rd_data, o_res_code, o_ram_en, o_ram_we, o_ram_be, o_ram_addr, o_ram_wr_data
   );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, write-lane placement and read extraction from (off, count)
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]             off,
   input  logic [MEM_COUNT_W-1:0] count,
   input  logic [WORD_W-1:0]      wr_data,
   input  logic [WORD_W-1:0]      rd_lo,
   input  logic [WORD_W-1:0]      rd_hi,
   output logic                   split,
   output logic [3:0]             be_lo,
   output logic [3:0]             be_hi,
   output logic [WORD_W-1:0]      wr_lo,
   output logic [WORD_W-1:0]      wr_hi,
   output logic [WORD_W-1:0]      rd_data
);

   logic [4:0]          sh;
   logic [3:0]          lanes;
   logic [7:0]          be_span;
   logic [2*WORD_W-1:0] wr_span;
   logic [2*WORD_W-1:0] rd_span;
   logic [WORD_W-1:0]   rd_mask;

   // Two-word spans: the low word belongs to the first access, the high word to the second.
   always_comb begin
      sh      = {off, 3'b000};
      lanes   = count_lanes(count);
      be_span = {4'b0000, lanes} << off;
      wr_span = {{WORD_W{1'b0}}, wr_data} << sh;
      rd_span = split ? {rd_hi, rd_lo} : {{WORD_W{1'b0}}, rd_hi};
      rd_mask = '0;
      for (int i = 0; i < 4; i++) begin
         rd_mask[8*i +: 8] = {8{lanes[i]}};
      end
      rd_data = WORD_W'(rd_span >> sh) & rd_mask;
   end

   assign split = |be_span[7:4];
   assign be_lo = be_span[3:0];
   assign be_hi = be_span[7:4];
   assign wr_lo = wr_span[WORD_W-1:0];
   assign wr_hi = wr_span[2*WORD_W-1:WORD_W];

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - data-memory controller: byte/half/word requests onto a word RAM, split and range handling
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int MEM_BYTES  = 4096,
   parameter int RAM_ADDR_W = 10
) (
   input  logic      clk,
   input  logic      clr,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACC0, ST_ACC1, ST_RESP} state_t;

   state_t                 state, state_nx;
   logic [RAM_ADDR_W-1:0]  wa_q;
   logic [1:0]             off_q;
   logic [MEM_COUNT_W-1:0] count_q;
   logic                   we_q;
   logic [WORD_W-1:0]      wd_q;
   logic                   err_q;
   logic [WORD_W-1:0]      lowbuf_q;

   logic [2:0]             req_bytes;
   logic [ADDR_W:0]        req_last;
   logic                   req_err;
   logic                   accept;

   logic                   split;
   logic [3:0]             be_lo, be_hi;
   logic [WORD_W-1:0]      wr_lo, wr_hi, align_rd;

   // One bit wider than the address so the last-byte sum cannot wrap.
   always_comb begin
      req_bytes = count_bytes(bus.i_req_count);
      req_last  = {1'b0, bus.i_req_addr} + {{(ADDR_W-2){1'b0}}, req_bytes} - {{ADDR_W{1'b0}}, 1'b1};
      req_err   = req_last >= (ADDR_W+1)'(MEM_BYTES);
      accept    = (bus.i_req_count != MEM_COUNT_NONE) && (state == ST_IDLE || state == ST_RESP);
   end

   mem_lane_align u_align (
      .off     (off_q),
      .count   (count_q),
      .wr_data (wd_q),
      .rd_lo   (lowbuf_q),
      .rd_hi   (bus.i_ram_rd_data),
      .split   (split),
      .be_lo   (be_lo),
      .be_hi   (be_hi),
      .wr_lo   (wr_lo),
      .wr_hi   (wr_hi),
      .rd_data (align_rd)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_RESP: state_nx = accept ? (req_err ? ST_RESP : ST_ACC0) : ST_IDLE;
         ST_ACC0:          state_nx = split ? ST_ACC1 : ST_RESP;
         ST_ACC1:          state_nx = ST_RESP;
         default:          state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wa_q     <= '0;
         off_q    <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         wd_q     <= '0;
         err_q    <= 1'b0;
         lowbuf_q <= '0;
      end else begin
         if (accept) begin
            wa_q    <= bus.i_req_addr[RAM_ADDR_W+1:2];
            off_q   <= bus.i_req_addr[1:0];
            count_q <= bus.i_req_count;
            we_q    <= bus.i_req_wr_en;
            wd_q    <= bus.i_req_wr_data;
            err_q   <= req_err;
         end
         // The first word of a split load arrives while the second is being issued.
         if (state == ST_ACC1 && !we_q) begin
            lowbuf_q <= bus.i_ram_rd_data;
         end
      end
   end

   always_comb begin
      bus.o_res_code    = MEM_CODE_IDLE;
      bus.o_res_rd_data = '0;
      bus.o_ram_en      = 1'b0;
      bus.o_ram_we      = 1'b0;
      bus.o_ram_be      = 4'b0000;
      bus.o_ram_addr    = '0;
      bus.o_ram_wr_data = '0;
      case (state)
         ST_ACC0: begin
            bus.o_res_code    = MEM_CODE_BUSY;
            bus.o_ram_en      = 1'b1;
            bus.o_ram_we      = we_q;
            bus.o_ram_be      = be_lo;
            bus.o_ram_addr    = wa_q;
            bus.o_ram_wr_data = wr_lo;
         end
         ST_ACC1: begin
            bus.o_res_code    = MEM_CODE_BUSY;
            bus.o_ram_en      = 1'b1;
            bus.o_ram_we      = we_q;
            bus.o_ram_be      = be_hi;
            bus.o_ram_addr    = wa_q + {{(RAM_ADDR_W-1){1'b0}}, 1'b1};
            bus.o_ram_wr_data = wr_hi;
         end
         ST_RESP: begin
            bus.o_res_code    = err_q ? MEM_CODE_ERROR : MEM_CODE_VALID;
            bus.o_res_rd_data = (err_q || we_q) ? '0 : align_rd;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a behavioural word RAM
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   typedef struct {
      logic [1:0]  code;
      logic [31:0] data;
      int          cyc;
   } resp_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [9:0]  addr;
      logic [31:0] wd;
   } ram_t;

   logic clk = 1'b0;
   logic clr;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   resp_t resp_q[$];
   ram_t  ram_q[$];
   logic [31:0] mem [1024] = '{default: '0};

   mem_ctrl_if #(.RAM_ADDR_W(10)) bus ();

   mem_ctrl #(.MEM_BYTES(4096), .RAM_ADDR_W(10)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.o_ram_en === 1'b1) begin
         bus.i_ram_rd_data <= mem[bus.o_ram_addr];
         if (bus.o_ram_we === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
               if (bus.o_ram_be[i]) mem[bus.o_ram_addr][8*i +: 8] <= bus.o_ram_wr_data[8*i +: 8];
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_code"}, 64'(bus.o_res_code), 64'(MEM_CODE_IDLE));
      chk({tag, "_rd"},   64'(bus.o_res_rd_data), 64'd0);
      chk({tag, "_en"},   64'(bus.o_ram_en), 64'd0);
      chk({tag, "_we"},   64'(bus.o_ram_we), 64'd0);
      chk({tag, "_be"},   64'(bus.o_ram_be), 64'd0);
   endtask

   task automatic monitor();
      ram_t  r;
      resp_t e;
      forever begin
         @(negedge clk);
         if (bus.o_ram_en === 1'b1) begin
            if (ram_q.size() == 0) begin
               chk("ram_unexpected", 64'(bus.o_ram_addr), 64'hFFFF);
            end else begin
               r = ram_q.pop_front();
               chk("ram_access", 64'({bus.o_ram_we, bus.o_ram_be, bus.o_ram_addr, bus.o_ram_wr_data}),
                   64'({r.we, r.be, r.addr, r.wd}));
            end
         end
         if (bus.o_ram_we === 1'b1 && bus.o_ram_en !== 1'b1) begin
            chk("we_without_en", 64'(bus.o_ram_en), 64'd1);
         end
         if (bus.o_res_code == MEM_CODE_VALID || bus.o_res_code == MEM_CODE_ERROR) begin
            if (resp_q.size() == 0) begin
               chk("resp_unexpected", 64'(bus.o_res_code), 64'(MEM_CODE_IDLE));
            end else begin
               e = resp_q.pop_front();
               chk("resp_code", 64'(bus.o_res_code), 64'(e.code));
               chk("resp_data", 64'(bus.o_res_rd_data), 64'(e.data));
               chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ram_exp(input logic we, input logic [3:0] be, input logic [9:0] addr, input logic [31:0] wd);
      ram_q.push_back('{we: we, be: be, addr: addr, wd: wd});
   endtask

   // Presents one request for a single cycle; lat is counted from the request cycle.
   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [1:0] cnt,
                      input logic [1:0] code, input logic [31:0] rd, input int lat);
      bus.i_req_addr    = a;
      bus.i_req_wr_data = d;
      bus.i_req_wr_en   = we;
      bus.i_req_count   = cnt;
      resp_q.push_back('{code: code, data: rd, cyc: cyc + lat});
      @(posedge clk);
      #1;
      bus.i_req_count   = MEM_COUNT_NONE;
   endtask

   initial begin
      clr               = 1'b1;
      bus.i_req_addr    = '0;
      bus.i_req_wr_data = '0;
      bus.i_req_wr_en   = 1'b0;
      bus.i_req_count   = MEM_COUNT_NONE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk);
      #1;
      clr = 1'b0;
      fork
         monitor();
      join_none
      gap(1);

      ram_exp(1'b1, 4'b1111, 10'd4, 32'hDEADBEEF);
      req(32'h10, 32'hDEADBEEF, 1'b1, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h0, 2);
      gap(3);
      ram_exp(1'b0, 4'b1111, 10'd4, 32'h0);
      req(32'h10, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_VALID, 32'hDEADBEEF, 2);
      gap(3);
      ram_exp(1'b0, 4'b1000, 10'd4, 32'h0);
      req(32'h13, 32'h0, 1'b0, MEM_COUNT_BYTE, MEM_CODE_VALID, 32'h000000DE, 2);
      gap(3);

      ram_exp(1'b1, 4'b1100, 10'd3, 32'h33440000);
      ram_exp(1'b1, 4'b0011, 10'd4, 32'h00001122);
      req(32'h0E, 32'h11223344, 1'b1, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h0, 3);
      gap(3);
      ram_exp(1'b0, 4'b1100, 10'd3, 32'h0);
      ram_exp(1'b0, 4'b0011, 10'd4, 32'h0);
      req(32'h0E, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h11223344, 3);
      gap(3);

      // Top of memory: 0xFFE..0xFFF is the last legal half.
      ram_exp(1'b1, 4'b1100, 10'd1023, 32'hABCD0000);
      req(32'hFFE, 32'h0000ABCD, 1'b1, MEM_COUNT_HALF, MEM_CODE_VALID, 32'h0, 2);
      gap(3);
      ram_exp(1'b0, 4'b1100, 10'd1023, 32'h0);
      req(32'hFFE, 32'h0, 1'b0, MEM_COUNT_HALF, MEM_CODE_VALID, 32'h0000ABCD, 2);
      gap(3);
      req(32'hFFF, 32'h0, 1'b0, MEM_COUNT_HALF, MEM_CODE_ERROR, 32'h0, 1);
      gap(2);
      req(32'hFFD, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_ERROR, 32'h0, 1);
      gap(2);
      req(32'h1000, 32'h0, 1'b1, MEM_COUNT_BYTE, MEM_CODE_ERROR, 32'h0, 1);
      gap(2);

      ram_exp(1'b1, 4'b1111, 10'd0, 32'h01020304);
      req(32'h0, 32'h01020304, 1'b1, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h0, 2);
      gap(3);
      ram_exp(1'b1, 4'b1111, 10'd1, 32'h05060708);
      req(32'h4, 32'h05060708, 1'b1, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h0, 2);
      gap(3);
      ram_exp(1'b0, 4'b1111, 10'd0, 32'h0);
      ram_exp(1'b0, 4'b1111, 10'd1, 32'h0);
      req(32'h0, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h01020304, 2);
      gap(1);
      req(32'h4, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h05060708, 2);
      gap(3);

      // Reset during the first half of a split store: word 12 must stay untouched.
      ram_exp(1'b1, 4'b1100, 10'd11, 32'h77880000);
      bus.i_req_addr    = 32'h2E;
      bus.i_req_wr_data = 32'h55667788;
      bus.i_req_wr_en   = 1'b1;
      bus.i_req_count   = MEM_COUNT_WORD;
      @(posedge clk);
      #1;
      bus.i_req_count   = MEM_COUNT_NONE;
      clr               = 1'b1;
      @(posedge clk);
      #1;
      chk_idle("clr_mid");
      clr = 1'b0;
      gap(3);
      ram_exp(1'b0, 4'b1100, 10'd11, 32'h0);
      ram_exp(1'b0, 4'b0011, 10'd12, 32'h0);
      req(32'h2E, 32'h0, 1'b0, MEM_COUNT_WORD, MEM_CODE_VALID, 32'h00007788, 3);
      gap(4);

      chk("ram_q_drained", 64'(ram_q.size()), 64'd0);
      chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
